// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: request payload, result-select codes,
// arbitration modes and the writeback data selector.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    RESULT_ALU = 2'b00,
    RESULT_MEM = 2'b01,
    RESULT_PC  = 2'b10
  } result_sel_t;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  typedef struct packed {
    logic        RegW;
    logic [4:0]  rd;
    logic [1:0]  ResultSelect;
    logic [31:0] ALUResult;
    logic [31:0] MemData;
    logic [31:0] PC4;
  } wb_req_t;

  // Unused select code 2'b11 falls back to the ALU result.
  function automatic logic [31:0] wb_result(input wb_req_t r);
    case (r.ResultSelect)
      RESULT_MEM: return r.MemData;
      RESULT_PC:  return r.PC4;
      default:    return r.ALUResult;
    endcase
  endfunction

endpackage

// File: rtl/wb_arbiter_chan_fifo.sv
// Per-channel request queue: power-of-two depth circular buffer, no pop bypass.
module wb_chan_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int unsigned AW = $clog2(QDEPTH);

  wb_req_t        mem [QDEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(QDEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: NUM_CH request queues share one register-file write port,
// granted by fixed priority or round robin, with registered WE3/A3/WD3.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned QDEPTH   = 2,
  parameter arb_mode_t   ARB_MODE = ARB_FIXED
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  input  wb_req_t [NUM_CH-1:0]     ch_req,
  output logic                     WE3,
  output logic [4:0]               A3,
  output logic [31:0]              WD3,
  output logic [$clog2(NUM_CH):0]  wb_ch
);

  localparam int unsigned CHW = $clog2(NUM_CH) + 1;

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] pop;
  wb_req_t           head [NUM_CH];
  logic [CHW-1:0]    last_grant;
  logic [CHW-1:0]    grant;
  logic              any_grant;
  wb_req_t           sel_req;
  int unsigned       idx;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wb_chan_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ch_valid[i]),
      .pop   (pop[i]),
      .din   (ch_req[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  assign ch_ready = ~full;

  // Walk channels in priority order; the inner loop keeps every index constant.
  always_comb begin
    any_grant = 1'b0;
    grant     = '0;
    sel_req   = '0;
    pop       = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (ARB_MODE == ARB_RR) ? (32'(last_grant) + 1 + k) % NUM_CH : k;
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        if (!any_grant && !empty[j] && (j == idx)) begin
          any_grant = 1'b1;
          grant     = CHW'(j);
          sel_req   = head[j];
        end
      end
    end
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      pop[j] = any_grant && (grant == CHW'(j));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= CHW'(NUM_CH - 1);
    end else if (any_grant) begin
      last_grant <= grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WE3   <= 1'b0;
      A3    <= '0;
      WD3   <= '0;
      wb_ch <= '0;
    end else if (any_grant) begin
      WE3   <= sel_req.RegW && (sel_req.rd != '0);
      A3    <= sel_req.rd;
      WD3   <= wb_result(sel_req);
      wb_ch <= grant;
    end else begin
      WE3   <= 1'b0;
    end
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of result channels (1..4).
REQ-002 SHALL have parameter QDEPTH, default 2, entries per channel queue (power of two, >=2).
REQ-003 SHALL have parameter ARB_MODE, default ARB_FIXED, arbitration mode (ARB_FIXED or ARB_RR).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock, asynchronous and active-high.
REQ-006 SHALL have port ch_valid  input  NUM_CH  per-channel request valid.
REQ-007 SHALL have port ch_ready  output  NUM_CH  per-channel queue can accept.
REQ-008 SHALL have port ch_req  input  NUM_CH x wb_req_t  per-channel request {RegW, rd[4:0], ResultSelect, ALUResult[31:0], MemData[31:0], PC4[31:0]}.
REQ-009 SHALL have port WE3  output  1  register-file write enable.
REQ-010 SHALL have port A3  output  5  register-file write address.
REQ-011 SHALL have port WD3  output  32  register-file write data.
REQ-012 SHALL have port wb_ch  output  $clog2(NUM_CH)+1  index of channel written this cycle (debug).

Function
REQ-013 Push: channel i enqueues ch_req[i] when ch_valid[i] && ch_ready[i] at a rising clk.
REQ-014 ch_ready[i] = (count[i] < QDEPTH); no same-cycle pop bypass, so a full queue deasserts ready even if popped that cycle.
REQ-015 Each cycle at most one non-empty queue is popped; the grant is computed from queue state before that edge's pushes.
REQ-016 ARB_FIXED: lowest-index non-empty channel wins.
REQ-017 ARB_RR: search starts at channel last_grant+1 mod NUM_CH; last_grant updates only on a pop.
REQ-018 Pop registers outputs: A3 = rd; WE3 = RegW && (rd != 0); wb_ch = granted index.
REQ-019 Pop WD3 mux: RESULT_ALU -> ALUResult, RESULT_MEM -> MemData, RESULT_PC -> PC4, any other code -> ALUResult.
REQ-020 Latency: request pushed at edge N to an empty queue with no competitor appears on WE3/A3/WD3 after edge N+1.
REQ-021 No pop in a cycle: next edge drives WE3=0; A3, WD3 and wb_ch hold their last values.
REQ-022 Push and pop on the same queue at the same edge: count unchanged; entry order strictly FIFO; pointers wrap mod QDEPTH.
REQ-023 Requests with RegW=0 or rd=0 still occupy a slot and consume a grant, but produce WE3=0.

Reset
REQ-024 While rst is high, asynchronously: all queues empty; ch_ready all 1; WE3=0; A3=0; WD3=0; wb_ch=0; last_grant=NUM_CH-1.
REQ-025 Reset mid-operation discards all queued entries; no write issues from pre-reset state after release.

Structure
REQ-026 wb_req_t, the result-select enum (RESULT_ALU/MEM/PC) and ARB_FIXED/ARB_RR constants SHALL live in the shared package Pkg.
REQ-027 The per-channel queue SHALL be sub-module wb_chan_fifo (params QDEPTH; push, pop, full, empty, head), instantiated NUM_CH times.
REQ-028 Arbiter, result mux and output register SHALL be in wb_arbiter; no latches, one always_ff per register group.

Verification
REQ-029 Single channel: ch0 push {RegW=1, rd=5, ALU, ALUResult=0x1234} -> next edge WE3=1, A3=5, WD3=0x00001234, wb_ch=0.
REQ-030 Mux/x0: push MEM MemData=0xDEADBEEF rd=7 -> WD3=0xDEADBEEF; push PC PC4=0x104 rd=0 -> WE3=0, WD3=0x104.
REQ-031 Fixed priority: ch0 and ch1 push same edge (rd=1, rd=2) -> A3=1 then A3=2 on consecutive cycles.
REQ-032 Round robin NUM_CH=3: all three channels kept non-empty -> wb_ch sequence 0,1,2,0,1,2.
REQ-033 Full: QDEPTH=2, ch1 pushes 3 back-to-back while ch0 is busy -> ch1 ready=0 after 2 entries; third accepted only once ready returns; FIFO order kept.
REQ-034 Reset mid-op: rst asserted with entries queued -> WE3=0 immediately; after release no stale writes and all ch_ready=1.
